// File: rtl/pipewb_regfile_pkg.sv
// Shared CPU defines: register-file geometry used by writeback and the ID-stage hazard/forwarding logic.
package pipewb_regfile_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int NREGS    = 2 ** AW_DEF;
    localparam int ZERO_REG = 0;

    // MEM/WB pipeline-register field widths as seen by the writeback stage
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_W      = MEMWB_CTRL_W + 2 * DW_DEF + AW_DEF;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/pipewb_regfile_sel.sv
// Writeback source mux: load data or ALU result onto wdi; not gated by the write enable.
module pipewb_sel
    import pipewb_regfile_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          wm2reg,
    input  logic [DW-1:0] wmo,
    input  logic [DW-1:0] walu,
    output logic [DW-1:0] wdi
);

    always_comb begin
        wdi = walu;
        if (wb_src_e'(wm2reg) == WB_SRC_MEM) begin
            wdi = wmo;
        end
    end

endmodule

// File: rtl/pipewb_regfile.sv
// Writeback stage and register file with zero-latency read ports and a same-cycle write-to-read bypass.
module pipewb_regfile
    import pipewb_regfile_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wwreg,
    input  logic          wm2reg,
    input  logic [DW-1:0] wmo,
    input  logic [DW-1:0] walu,
    input  logic [AW-1:0] wrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wdi
);

    localparam int N = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    // r0 has no storage; entries start at 1
    logic [DW-1:0] regs_q [1:N-1];
    logic [DW-1:0] regs_d [1:N-1];
    logic          write_en;
    logic          bypass_en;

    pipewb_sel #(.DW(DW)) u_sel (
        .wm2reg (wm2reg),
        .wmo    (wmo),
        .walu   (walu),
        .wdi    (wdi)
    );

    assign write_en  = wwreg && !clr && (wrn != ZERO_ADDR);
    assign bypass_en = BYPASS && write_en;

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < N; i++) begin
            if (clr) begin
                regs_d[i] = '0;
            end else if (write_en && (wrn == AW'(i))) begin
                regs_d[i] = wdi;
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Address 0 matches no stored entry and is excluded from bypass, so it reads zero
    always_comb begin
        qa = '0;
        qb = '0;
        for (int i = 1; i < N; i++) begin
            if (rna == AW'(i)) qa = regs_q[i];
            if (rnb == AW'(i)) qb = regs_q[i];
        end
        if (bypass_en && (wrn == rna)) qa = wdi;
        if (bypass_en && (wrn == rnb)) qb = wdi;
    end

endmodule
